// File: rtl/axi_pkg.sv
// Shared AXI definitions for the AXI-to-stream responder.
// Contents: response and burst codes, responder FSM states, and a helper
// that converts a bus byte count to the matching AXI size code.
package axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_WRESP,
    ST_READ
  } state_t;

  // AXI size code (log2 of bytes per beat) for a power-of-two byte count.
  function automatic logic [2:0] axi_size_of(input int unsigned nbytes);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == nbytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_to_axis_responder_if.sv
// Bus bundle for axi_to_axis_responder: AXI4 slave channels (AW/W/B/AR/R)
// plus the stream-side command (m_a*), write (m_w*) and read (s_r*) channels.
// Modports: slave = responder view, master = AXI master + stream endpoint view.
interface axi_to_axis_responder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 8
);

  logic [ID_WIDTH-1:0]   s_axi_awid;
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0]            s_axi_awlen;
  logic [2:0]            s_axi_awsize;
  logic [1:0]            s_axi_awburst;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;

  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_WIDTH-1:0] s_axi_wstrb;
  logic                  s_axi_wlast;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;

  logic [ID_WIDTH-1:0]   s_axi_bid;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;

  logic [ID_WIDTH-1:0]   s_axi_arid;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic [1:0]            s_axi_arburst;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;

  logic [ID_WIDTH-1:0]   s_axi_rid;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  logic                  m_avalid;
  logic                  m_arnw;
  logic [ADDR_WIDTH-1:0] m_aaddr;
  logic [ADDR_WIDTH-1:0] m_abeats;
  logic                  m_aready;

  logic                  m_wvalid;
  logic                  m_wlast;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_wready;

  logic                  s_rvalid;
  logic                  s_rlast;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  s_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready,
    output m_avalid, m_arnw, m_aaddr, m_abeats,
    input  m_aready,
    output m_wvalid, m_wlast, m_wdata, m_wstrb,
    input  m_wready,
    input  s_rvalid, s_rlast, s_rdata,
    output s_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready,
    input  m_avalid, m_arnw, m_aaddr, m_abeats,
    output m_aready,
    input  m_wvalid, m_wlast, m_wdata, m_wstrb,
    output m_wready,
    output s_rvalid, s_rlast, s_rdata,
    input  s_rready
  );

endinterface

// File: rtl/axi_rr_arbiter.sv
// Two-request round-robin arbiter (write vs read address channel).
// Ports: aclk/resetn; en = arbitration allowed; req_w/req_r requests;
// gnt_w/gnt_r registered one-cycle grant pulses (directly usable as AXI ready).
module axi_rr_arbiter (
  input  logic aclk,
  input  logic resetn,
  input  logic en,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);

  logic prio_w;

  // A grant blocks a second grant while its pulse is still on the bus.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      gnt_w  <= 1'b0;
      gnt_r  <= 1'b0;
      prio_w <= 1'b1;
    end else begin
      gnt_w <= 1'b0;
      gnt_r <= 1'b0;
      if (en && !gnt_w && !gnt_r) begin
        if (req_w && (!req_r || prio_w)) begin
          gnt_w  <= 1'b1;
          prio_w <= ~prio_w;
        end else if (req_r) begin
          gnt_r  <= 1'b1;
          prio_w <= ~prio_w;
        end
      end
    end
  end

endmodule

// File: rtl/axi_to_axis_responder.sv
// AXI4 slave that terminates one burst at a time and re-emits it as a stream
// command (m_a*) followed by a write stream (m_w*) or read stream (s_r*).
// Ports: aclk, resetn (async active-low), bus = axi_to_axis_responder_if.slave.
module axi_to_axis_responder
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                     aclk,
  input  logic                     resetn,
  axi_to_axis_responder_if.slave   bus
);

  localparam logic [2:0] FULL_SIZE = axi_size_of(STRB_WIDTH);

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt;
  logic                  is_wr;
  logic                  err;
  logic                  m_avalid_q;
  logic                  m_arnw_q;
  logic [ADDR_WIDTH-1:0] m_aaddr_q;
  logic [ADDR_WIDTH-1:0] m_abeats_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  gnt_w;
  logic                  gnt_r;

  logic                  wr_act, rd_act, beat_last, w_hs, r_hs, wlast_err, rlast_err;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [2:0]            sel_size;
  logic [1:0]            sel_burst;

  axi_rr_arbiter u_arb (
    .aclk   (aclk),
    .resetn (resetn),
    .en     (state == ST_IDLE),
    .req_w  (bus.s_axi_awvalid),
    .req_r  (bus.s_axi_arvalid),
    .gnt_w  (gnt_w),
    .gnt_r  (gnt_r)
  );

  // Address fields of whichever channel is being accepted this cycle.
  assign sel_id    = gnt_w ? bus.s_axi_awid    : bus.s_axi_arid;
  assign sel_addr  = gnt_w ? bus.s_axi_awaddr  : bus.s_axi_araddr;
  assign sel_len   = gnt_w ? bus.s_axi_awlen   : bus.s_axi_arlen;
  assign sel_size  = gnt_w ? bus.s_axi_awsize  : bus.s_axi_arsize;
  assign sel_burst = gnt_w ? bus.s_axi_awburst : bus.s_axi_arburst;

  assign wr_act    = (state == ST_WRITE);
  assign rd_act    = (state == ST_READ);
  assign beat_last = (cnt == len_q);
  assign w_hs      = wr_act && bus.s_axi_wvalid && bus.m_wready;
  assign r_hs      = rd_act && bus.s_rvalid && bus.s_axi_rready;
  assign wlast_err = (bus.s_axi_wlast != beat_last);
  assign rlast_err = (bus.s_rlast != beat_last);

  assign bus.s_axi_awready = gnt_w;
  assign bus.s_axi_arready = gnt_r;
  assign bus.m_avalid      = m_avalid_q;
  assign bus.m_arnw        = m_arnw_q;
  assign bus.m_aaddr       = m_aaddr_q;
  assign bus.m_abeats      = m_abeats_q;
  assign bus.s_axi_bvalid  = bvalid_q;
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_bid     = id_q;

  // Write data path: a gated pass-through, last taken from the beat counter.
  assign bus.m_wvalid      = wr_act && bus.s_axi_wvalid;
  assign bus.s_axi_wready  = wr_act && bus.m_wready;
  assign bus.m_wlast       = wr_act && beat_last;
  assign bus.m_wdata       = bus.s_axi_wdata;
  assign bus.m_wstrb       = bus.s_axi_wstrb;

  // Read data path: source beats beyond counter-last are never accepted.
  assign bus.s_axi_rvalid  = rd_act && bus.s_rvalid;
  assign bus.s_rready      = rd_act && bus.s_axi_rready;
  assign bus.s_axi_rlast   = rd_act && beat_last;
  assign bus.s_axi_rdata   = bus.s_rdata;
  assign bus.s_axi_rid     = id_q;
  assign bus.s_axi_rresp   = (rd_act && (err || rlast_err)) ? RESP_SLVERR : RESP_OKAY;

  // Transaction sequencer; latches on the AW/AR handshake edge (grant pulse high).
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      id_q       <= '0;
      len_q      <= '0;
      cnt        <= '0;
      is_wr      <= 1'b0;
      err        <= 1'b0;
      m_avalid_q <= 1'b0;
      m_arnw_q   <= 1'b0;
      m_aaddr_q  <= '0;
      m_abeats_q <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_w || gnt_r) begin
            is_wr      <= gnt_w;
            id_q       <= sel_id;
            len_q      <= sel_len;
            cnt        <= '0;
            err        <= (sel_burst != BURST_INCR) || (sel_size != FULL_SIZE);
            m_avalid_q <= 1'b1;
            m_arnw_q   <= gnt_w;
            m_aaddr_q  <= sel_addr;
            m_abeats_q <= ADDR_WIDTH'(sel_len) + ADDR_WIDTH'(1);
            state      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.m_aready) begin
            m_avalid_q <= 1'b0;
            state      <= is_wr ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (w_hs) begin
            if (wlast_err) err <= 1'b1;
            if (beat_last) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (err || wlast_err) ? RESP_SLVERR : RESP_OKAY;
              cnt      <= '0;
              state    <= ST_WRESP;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_WRESP: begin
          if (bus.s_axi_bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            err      <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (r_hs) begin
            if (beat_last) begin
              cnt   <= '0;
              err   <= 1'b0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_to_axis_responder.sv
// Directed self-checking bench for axi_to_axis_responder.
module tb_axi_to_axis_responder;

  logic aclk;
  logic resetn;
  int   checks;
  int   failures;

  axi_to_axis_responder_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .ID_WIDTH(8)
  ) bus ();

  axi_to_axis_responder #(
    .ADDR_WIDTH(32), .STRB_WIDTH(4), .ID_WIDTH(8)
  ) dut (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len;
    bus.s_axi_awsize = size; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
  endtask

  task automatic set_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = len;
    bus.s_axi_arsize = size; bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
  endtask

  // Wait for a ready pulse, check which channel won, complete the handshake.
  task automatic wait_grant(input logic exp_w, input string tag);
    logic seen;
    logic got_w;
    seen = 1'b0;
    got_w = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (bus.s_axi_awready || bus.s_axi_arready) begin
        seen = 1'b1;
        got_w = bus.s_axi_awready;
      end
    end
    check({tag, "_grant_seen"}, seen, 1'b1);
    check({tag, "_grant_is_write"}, got_w, exp_w);
    step();
    if (got_w) bus.s_axi_awvalid = 1'b0;
    else bus.s_axi_arvalid = 1'b0;
    check({tag, "_ready_pulse_ends"}, bus.s_axi_awready | bus.s_axi_arready, 1'b0);
    check({tag, "_avalid_next"}, bus.m_avalid, 1'b1);
  endtask

  task automatic accept_cmd(input int stall, input logic exp_rnw, input logic [31:0] exp_addr,
                            input logic [31:0] exp_beats, input string tag);
    check({tag, "_arnw"}, bus.m_arnw, exp_rnw);
    check({tag, "_aaddr"}, bus.m_aaddr, exp_addr);
    check({tag, "_abeats"}, bus.m_abeats, exp_beats);
    for (int i = 0; i < stall; i++) step();
    if (stall > 0) check({tag, "_avalid_held"}, bus.m_avalid, 1'b1);
    bus.m_aready = 1'b1;
    step();
    bus.m_aready = 1'b0;
    check({tag, "_avalid_drop"}, bus.m_avalid, 1'b0);
  endtask

  task automatic write_beat(input logic [31:0] data, input logic [3:0] strb, input logic wlast,
                            input logic exp_mlast, input string tag);
    bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wlast = wlast;
    bus.s_axi_wvalid = 1'b1; bus.m_wready = 1'b1;
    #1;
    check({tag, "_wvalid"}, bus.m_wvalid, 1'b1);
    check({tag, "_wready"}, bus.s_axi_wready, 1'b1);
    check({tag, "_wdata"}, bus.m_wdata, data);
    check({tag, "_wstrb"}, bus.m_wstrb, strb);
    check({tag, "_wlast"}, bus.m_wlast, exp_mlast);
    step();
    bus.s_axi_wvalid = 1'b0; bus.m_wready = 1'b0; bus.s_axi_wlast = 1'b0;
  endtask

  task automatic check_b(input logic [7:0] exp_id, input logic [1:0] exp_resp, input string tag);
    check({tag, "_bvalid"}, bus.s_axi_bvalid, 1'b1);
    check({tag, "_bid"}, bus.s_axi_bid, exp_id);
    check({tag, "_bresp"}, bus.s_axi_bresp, exp_resp);
    step();
    check({tag, "_bvalid_stall"}, bus.s_axi_bvalid, 1'b1);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    check({tag, "_bvalid_done"}, bus.s_axi_bvalid, 1'b0);
  endtask

  // Stream source feeds base+index with s_rlast on the final beat.
  task automatic read_data(input int n, input logic [31:0] base, input logic [7:0] exp_id,
                           input logic [1:0] exp_resp, input bit stalls, input string tag);
    int src, rcv, lastc, cyc;
    logic hs;
    src = 0; rcv = 0; lastc = 0; cyc = 0;
    while (rcv < n && cyc < 4000) begin
      if (!bus.s_rvalid && src < n)
        bus.s_rvalid = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.s_rdata = base + 32'(src);
      bus.s_rlast = (src == n - 1);
      bus.s_axi_rready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      hs = bus.s_axi_rvalid && bus.s_axi_rready;
      if (hs) begin
        check({tag, "_rdata"}, bus.s_axi_rdata, base + 32'(rcv));
        check({tag, "_rlast"}, bus.s_axi_rlast, rcv == n - 1);
        check({tag, "_rid"}, bus.s_axi_rid, exp_id);
        check({tag, "_rresp"}, bus.s_axi_rresp, exp_resp);
        if (bus.s_axi_rlast) lastc++;
      end
      step();
      cyc++;
      if (hs) begin
        src++; rcv++; bus.s_rvalid = 1'b0;
      end
    end
    check({tag, "_beats"}, rcv, n);
    check({tag, "_rlast_count"}, lastc, 1);
    bus.s_rvalid = 1'b1; bus.s_axi_rready = 1'b1;
    #1;
    check({tag, "_no_overrun"}, bus.s_rready, 1'b0);
    bus.s_rvalid = 1'b0; bus.s_axi_rready = 1'b0; bus.s_rlast = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
    bus.s_axi_awsize = '0; bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
    bus.s_axi_arsize = '0; bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    bus.m_aready = 1'b0; bus.m_wready = 1'b0;
    bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; bus.s_rdata = '0;

    // Reset values
    #1;
    check("rst_awready", bus.s_axi_awready, 1'b0);
    check("rst_arready", bus.s_axi_arready, 1'b0);
    check("rst_avalid", bus.m_avalid, 1'b0);
    check("rst_bvalid", bus.s_axi_bvalid, 1'b0);
    check("rst_bresp", bus.s_axi_bresp, 2'b00);
    check("rst_rresp", bus.s_axi_rresp, 2'b00);
    step(); step();
    resetn = 1'b1;
    step();

    // 1: write id=5 addr=0x100 len=3, wlast on beat 4
    set_aw(8'd5, 32'h100, 8'd3, 3'd2, 2'b01);
    wait_grant(1'b1, "t1");
    accept_cmd(0, 1'b1, 32'h100, 32'd4, "t1");
    bus.s_axi_wvalid = 1'b1; bus.m_wready = 1'b0;
    #1;
    check("t1_wready_stall", bus.s_axi_wready, 1'b0);
    step();
    write_beat(32'hA0A0_0001, 4'hF, 1'b0, 1'b0, "t1_b1");
    write_beat(32'hA0A0_0002, 4'hA, 1'b0, 1'b0, "t1_b2");
    write_beat(32'hA0A0_0003, 4'h5, 1'b0, 1'b0, "t1_b3");
    write_beat(32'hA0A0_0004, 4'hF, 1'b1, 1'b1, "t1_b4");
    check_b(8'd5, 2'b00, "t1");

    // 2: read id=9 addr=0x40 len=0
    set_ar(8'd9, 32'h40, 8'd0, 3'd2, 2'b01);
    wait_grant(1'b0, "t2");
    accept_cmd(0, 1'b0, 32'h40, 32'd1, "t2");
    read_data(1, 32'hC0DE_0000, 8'd9, 2'b00, 1'b0, "t2");

    // 3: AW and AR together, twice: write then read, then the new write
    set_aw(8'd1, 32'h10, 8'd0, 3'd2, 2'b01);
    set_ar(8'd2, 32'h20, 8'd0, 3'd2, 2'b01);
    wait_grant(1'b1, "t3a");
    accept_cmd(0, 1'b1, 32'h10, 32'd1, "t3a");
    check("t3a_ar_waits", bus.s_axi_arready, 1'b0);
    write_beat(32'h1111_1111, 4'hF, 1'b1, 1'b1, "t3a_b1");
    check_b(8'd1, 2'b00, "t3a");
    set_aw(8'd3, 32'h30, 8'd0, 3'd2, 2'b01);
    wait_grant(1'b0, "t3b");
    accept_cmd(0, 1'b0, 32'h20, 32'd1, "t3b");
    read_data(1, 32'h0000_00A0, 8'd2, 2'b00, 1'b0, "t3b");
    wait_grant(1'b1, "t3c");
    accept_cmd(0, 1'b1, 32'h30, 32'd1, "t3c");
    write_beat(32'h3333_3333, 4'hF, 1'b1, 1'b1, "t3c_b1");
    check_b(8'd3, 2'b00, "t3c");

    // 4: write len=1, wlast wrongly on beat 1 -> SLVERR
    set_aw(8'd4, 32'h400, 8'd1, 3'd2, 2'b01);
    wait_grant(1'b1, "t4");
    accept_cmd(0, 1'b1, 32'h400, 32'd2, "t4");
    write_beat(32'h4444_0001, 4'hF, 1'b1, 1'b0, "t4_b1");
    write_beat(32'h4444_0002, 4'hF, 1'b0, 1'b1, "t4_b2");
    check_b(8'd4, 2'b10, "t4");

    // 5: FIXED burst read completes with SLVERR
    set_ar(8'd6, 32'h80, 8'd0, 3'd2, 2'b00);
    wait_grant(1'b0, "t5");
    accept_cmd(0, 1'b0, 32'h80, 32'd1, "t5");
    read_data(1, 32'h0000_00B0, 8'd6, 2'b10, 1'b0, "t5");

    // 6: read len=255, command stalled 10 cycles, random stalls
    set_ar(8'h11, 32'h1000, 8'd255, 3'd2, 2'b01);
    wait_grant(1'b0, "t6");
    accept_cmd(10, 1'b0, 32'h1000, 32'd256, "t6");
    read_data(256, 32'h5000_0000, 8'h11, 2'b00, 1'b1, "t6");

    // 7: reset during beat 3 of a 4-beat write
    set_aw(8'd3, 32'h200, 8'd3, 3'd2, 2'b01);
    wait_grant(1'b1, "t7");
    accept_cmd(0, 1'b1, 32'h200, 32'd4, "t7");
    write_beat(32'h7777_0001, 4'hF, 1'b0, 1'b0, "t7_b1");
    write_beat(32'h7777_0002, 4'hF, 1'b0, 1'b0, "t7_b2");
    bus.s_axi_wvalid = 1'b1; bus.m_wready = 1'b1; bus.s_axi_rready = 1'b1;
    resetn = 1'b0;
    #1;
    check("t7_rst_wvalid", bus.m_wvalid, 1'b0);
    check("t7_rst_wready", bus.s_axi_wready, 1'b0);
    check("t7_rst_bvalid", bus.s_axi_bvalid, 1'b0);
    check("t7_rst_rvalid", bus.s_axi_rvalid, 1'b0);
    check("t7_rst_srready", bus.s_rready, 1'b0);
    check("t7_rst_avalid", bus.m_avalid, 1'b0);
    check("t7_rst_awready", bus.s_axi_awready, 1'b0);
    step(); step();
    resetn = 1'b1;
    bus.s_axi_wvalid = 1'b0; bus.m_wready = 1'b0; bus.s_axi_rready = 1'b0;
    step(); step(); step();
    check("t7_no_bvalid", bus.s_axi_bvalid, 1'b0);
    check("t7_idle_avalid", bus.m_avalid, 1'b0);
    set_aw(8'd7, 32'h300, 8'd0, 3'd2, 2'b01);
    wait_grant(1'b1, "t7n");
    accept_cmd(0, 1'b1, 32'h300, 32'd1, "t7n");
    write_beat(32'h7070_7070, 4'h3, 1'b1, 1'b1, "t7n_b1");
    check_b(8'd7, 2'b00, "t7n");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
